// File: rtl/sci_cmd_sequencer.sv
// sci_cmd_sequencer
//   Shares one SCI command link among NREQ requesters. A round-robin arbiter
//   grants one requester, the block frames its command byte as
//   EB 90 01 CMD CHK (CHK = 01 + CMD), streams the frame to the UART TX byte
//   path, then waits for the decoded reply. A missing reply (timeout) is
//   retried up to MAX_RETRY times; the requester receives a one-cycle done
//   pulse together with a 2-bit result code.
//
// Build option
//   SCI_CMD_RETRY_ON_ERR_EN : when defined, an error reply is retried the same
//                             way as a timeout; when undefined, an error reply
//                             completes immediately with result 10.
//
// Ports
//   clk       in   1       system clock
//   rst_n     in   1       asynchronous active-low reset
//   req       in   NREQ    request level per requester, held until its done
//   cmd       in   8*NREQ  command byte of requester i at cmd[8*i +: 8]
//   done      out  NREQ    one-hot, one-cycle completion pulse
//   result    out  2       00 correct, 01 status, 10 error, 11 timeout
//   busy      out  1       high from grant until the cycle after done
//   tx_data   out  8       frame byte to UART TX
//   tx_valid  out  1       tx_data valid
//   tx_ready  in   1       UART TX accepts the byte on tx_valid && tx_ready
//   rpl_st    in   3       reply status, one-hot {st, error, correct}
//   rpl_new   in   1       one-cycle pulse, rpl_st valid in that cycle
module sci_cmd_sequencer #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 100000,
  parameter int MAX_RETRY   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] cmd,
  output logic [NREQ-1:0]   done,
  output logic [1:0]        result,
  output logic              busy,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [2:0]        rpl_st,
  input  logic              rpl_new
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] RES_OK  = 2'b00;
  localparam logic [1:0] RES_ST  = 2'b01;
  localparam logic [1:0] RES_ERR = 2'b10;
  localparam logic [1:0] RES_TMO = 2'b11;

  logic [1:0]    state_q,  state_d;
  logic [IW-1:0] rr_q,     rr_d;
  logic [IW-1:0] gnt_q,    gnt_d;
  logic [7:0]    cmd_q,    cmd_d;
  logic [2:0]    idx_q,    idx_d;
  logic [TW-1:0] timer_q,  timer_d;
  logic [RW-1:0] retry_q,  retry_d;
  logic [1:0]    result_q, result_d;

  logic          arb_hit;
  logic [IW-1:0] arb_idx;
  logic [IW:0]   arb_sum;
  logic [7:0]    arb_cmd;

  function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [7:0] c);
    case (i)
      3'd0:    frame_byte = 8'hEB;
      3'd1:    frame_byte = 8'h90;
      3'd2:    frame_byte = 8'h01;
      3'd3:    frame_byte = c;
      default: frame_byte = c + 8'h01;
    endcase
  endfunction

  // Round-robin search: first requester at or after rr_q, wrapping past NREQ-1.
  // The sum is one bit wider so the wrap also works for non-power-of-2 NREQ.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    arb_sum = '0;
    for (int k = 0; k < NREQ; k++) begin
      arb_sum = {1'b0, rr_q} + (IW+1)'(k);
      if (arb_sum >= (IW+1)'(NREQ)) begin
        arb_sum = arb_sum - (IW+1)'(NREQ);
      end
      if (!arb_hit && req[arb_sum[IW-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = arb_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    arb_cmd = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_idx == IW'(k)) begin
        arb_cmd = cmd[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    cmd_d    = cmd_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          state_d = S_SEND;
          gnt_d   = arb_idx;
          cmd_d   = arb_cmd;
          idx_d   = 3'd0;
          rr_d    = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
        end
      end

      // A reply arriving here belongs to an earlier attempt and is dropped.
      S_SEND: begin
        if (tx_ready) begin
          if (idx_q == 3'd4) begin
            state_d = S_WAIT;
            idx_d   = 3'd0;
            timer_d = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      // A reply in the expiry cycle takes priority over the timeout.
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (rpl_new) begin
          if (rpl_st == 3'b001) begin
            state_d  = S_DONE;
            result_d = RES_OK;
          end else if (rpl_st == 3'b100) begin
            state_d  = S_DONE;
            result_d = RES_ST;
          end else begin
`ifdef SCI_CMD_RETRY_ON_ERR_EN
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = S_SEND;
              idx_d   = 3'd0;
            end else begin
              state_d  = S_DONE;
              result_d = RES_ERR;
            end
`else
            state_d  = S_DONE;
            result_d = RES_ERR;
`endif
          end
        end else if (timer_q == TIMER_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = S_SEND;
            idx_d   = 3'd0;
          end else begin
            state_d  = S_DONE;
            result_d = RES_TMO;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        retry_d = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      gnt_q    <= '0;
      idx_q    <= 3'd0;
      timer_q  <= '0;
      retry_q  <= '0;
      result_q <= RES_OK;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      result_q <= result_d;
    end
  end

  // Latched command byte is pure data; it is only observed while in SEND.
  always_ff @(posedge clk) begin
    cmd_q <= cmd_d;
  end

  // Outputs decode straight from registered state, so reset forces them low at once.
  assign tx_valid = (state_q == S_SEND);
  assign tx_data  = tx_valid ? frame_byte(idx_q, cmd_q) : 8'h00;
  assign busy     = (state_q != S_IDLE);
  assign result   = result_q;

  always_comb begin
    done = '0;
    if (state_q == S_DONE) begin
      done[gnt_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_sci_cmd_sequencer.sv
module tb_sci_cmd_sequencer;

  localparam int NREQ = 3;
  localparam int TCYC = 16;
  localparam int MAXR = 2;

  localparam int K_OK   = 0;
  localparam int K_ST   = 1;
  localparam int K_ERR  = 2;
  localparam int K_BAD  = 3;
  localparam int K_NONE = 4;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic [NREQ-1:0]   req      = '0;
  logic [8*NREQ-1:0] cmd      = '0;
  logic [NREQ-1:0]   done;
  logic [1:0]        result;
  logic              busy;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic [2:0]        rpl_st   = 3'b000;
  logic              rpl_new  = 1'b0;

  always #5 clk = ~clk;

  sci_cmd_sequencer #(
    .NREQ        (NREQ),
    .TIMEOUT_CYC (TCYC),
    .MAX_RETRY   (MAXR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .cmd      (cmd),
    .done     (done),
    .result   (result),
    .busy     (busy),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rpl_st   (rpl_st),
    .rpl_new  (rpl_new)
  );

  typedef struct {
    logic [7:0] b;
    bit         gap;
  } txe_t;

  typedef struct {
    int         r;
    logic [1:0] res;
    bit         tmo;
  } dne_t;

  txe_t exp_tx[$];
  dne_t exp_done[$];
  int   dir_q[$];
  int   dly_q[$];

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int rdy_mode = 0;
  int model_rr = 0;
  bit end_req  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode != 0) tx_ready = (($urandom % 3) != 0);
      else               tx_ready = 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    bit         in_rst     = 1'b0;
    bit         prev_stall = 1'b0;
    bit         prev_valid = 1'b0;
    bit         chk_busy   = 1'b0;
    bit         final_seen = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    int         last_acc   = 0;
    int         rise_cyc   = 0;
    int         rpl_cyc    = 0;
    txe_t       e;
    dne_t       d;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        if (!in_rst) begin
          in_rst = 1'b1;
          #1;
          check("rst_done",     32'(done),     32'd0);
          check("rst_result",   32'(result),   32'd0);
          check("rst_busy",     32'(busy),     32'd0);
          check("rst_tx_valid", 32'(tx_valid), 32'd0);
          check("rst_tx_data",  32'(tx_data),  32'd0);
          exp_tx.delete();
          exp_done.delete();
          prev_stall = 1'b0;
          prev_valid = 1'b0;
          chk_busy   = 1'b0;
        end
      end else begin
        in_rst = 1'b0;
        if (chk_busy) begin
          check("busy_after_done", 32'(busy), 32'd0);
          chk_busy = 1'b0;
        end
        if (prev_stall) begin
          check("tx_hold_valid", 32'(tx_valid), 32'd1);
          check("tx_hold_data",  32'(tx_data),  32'(prev_data));
        end
        if (tx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = tx_valid;
        if (rpl_new) rpl_cyc = cyc;
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) begin
            check("tx_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_tx.pop_front();
            check("tx_byte", 32'(tx_data), 32'(e.b));
            if (e.gap) check("retry_gap", 32'(rise_cyc - last_acc), 32'(TCYC + 1));
          end
          last_acc = cyc;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (done != '0) begin
          if (exp_done.size() == 0) begin
            check("done_unexpected", 32'(done), 32'd0);
          end else begin
            d = exp_done.pop_front();
            check("done_vec", 32'(done), 32'(1 << d.r));
            check("result", 32'(result), 32'(d.res));
            if (d.tmo) check("done_latency_tmo", 32'(cyc - last_acc), 32'(TCYC + 1));
            else       check("done_latency_rpl", 32'(cyc - rpl_cyc), 32'd1);
            check("busy_at_done", 32'(busy), 32'd1);
            chk_busy = 1'b1;
          end
        end
        if (end_req && !final_seen) begin
          check("tx_leftover",   32'(exp_tx.size()),   32'd0);
          check("done_leftover", 32'(exp_done.size()), 32'd0);
          final_seen = 1'b1;
        end
      end
    end
  end

  function automatic int next_kind();
    int r;
    if (dir_q.size() != 0) return dir_q.pop_front();
    r = int'($urandom % 100);
    if (r < 35) return K_OK;
    if (r < 50) return K_ST;
    if (r < 65) return K_ERR;
    if (r < 75) return K_BAD;
    return K_NONE;
  endfunction

  function automatic logic [2:0] st_for(input int k);
    logic [2:0] bad [5];
    bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b101; bad[3] = 3'b110; bad[4] = 3'b111;
    case (k)
      K_OK:    return 3'b001;
      K_ST:    return 3'b100;
      K_ERR:   return 3'b010;
      default: return bad[$urandom % 5];
    endcase
  endfunction

  task automatic push_frame(input logic [7:0] c, input bit gap);
    txe_t e;
    e.gap = gap;  e.b = 8'hEB;        exp_tx.push_back(e);
    e.gap = 1'b0; e.b = 8'h90;        exp_tx.push_back(e);
    e.b = 8'h01;                      exp_tx.push_back(e);
    e.b = c;                          exp_tx.push_back(e);
    e.b = 8'(c + 8'h01);              exp_tx.push_back(e);
  endtask

  // Counts accepted bytes of one frame; optionally injects a stale reply mid-frame.
  task automatic wait_frame(input bit inject);
    int n;
    bit pend;
    bit used;
    n = 0; pend = 1'b0; used = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) n++;
      if (inject && !used && n == 2) pend = 1'b1;
      if (n == 5) break;
      @(posedge clk);
      #1;
      if (pend) begin
        rpl_st  = 3'($urandom);
        rpl_new = 1'b1;
        pend    = 1'b0;
        used    = 1'b1;
      end else begin
        rpl_new = 1'b0;
      end
    end
    rpl_new = 1'b0;
    if (n < 5) begin
      $display("FAIL frame_wait: got %0d bytes, want 5", n);
      $fatal(1, "frame wait expired");
    end
  endtask

  task automatic send_reply(input int k);
    int d;
    if (k == K_NONE) return;
    if (dly_q.size() != 0) d = dly_q.pop_front();
    else                   d = int'($urandom % TCYC);
    @(posedge clk);
    repeat (d) @(posedge clk);
    #1;
    rpl_st  = st_for(k);
    rpl_new = 1'b1;
    @(posedge clk);
    #1;
    rpl_new = 1'b0;
  endtask

  task automatic run_round(input logic [NREQ-1:0] rs, input logic [8*NREQ-1:0] cv, input bit inj);
    int              order[$];
    int              kinds[NREQ][MAXR+1];
    int              natt[NREQ];
    logic [NREQ-1:0] pend;
    int              g, a, k2, j;
    bit              fin, tmo;
    logic [1:0]      res;
    dne_t            dn;
    pend = rs;
    while (pend != '0) begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (model_rr + k) % NREQ;
        if (g < 0 && pend[j]) g = j;
      end
      model_rr = (g + 1) % NREQ;
      pend[g]  = 1'b0;
      order.push_back(g);
      a = 0; fin = 1'b0; tmo = 1'b0; res = 2'b00;
      while (!fin) begin
        k2 = next_kind();
        kinds[g][a] = k2;
        push_frame(cv[8*g +: 8], (a > 0) && (kinds[g][a-1] == K_NONE));
        case (k2)
          K_OK: begin res = 2'b00; fin = 1'b1; end
          K_ST: begin res = 2'b01; fin = 1'b1; end
          K_NONE: begin
            if (a < MAXR) a++;
            else begin res = 2'b11; tmo = 1'b1; fin = 1'b1; end
          end
          default: begin
`ifdef SCI_CMD_RETRY_ON_ERR_EN
            if (a < MAXR) a++;
            else begin res = 2'b10; fin = 1'b1; end
`else
            res = 2'b10; fin = 1'b1;
`endif
          end
        endcase
      end
      natt[g] = a + 1;
      dn.r = g; dn.res = res; dn.tmo = tmo;
      exp_done.push_back(dn);
    end
    dir_q.delete();

    @(posedge clk);
    #1;
    cmd = cv;
    req = rs;
    foreach (order[i]) begin
      g = order[i];
      for (int at = 0; at < natt[g]; at++) begin
        wait_frame(inj && ($urandom % 2 == 0));
        send_reply(kinds[g][at]);
      end
      fin = 1'b0;
      for (int t = 0; t < 100 && !fin; t++) begin
        @(negedge clk);
        if (done != '0) fin = 1'b1;
      end
      if (!fin) begin
        $display("FAIL done_wait: no done for requester %0d", g);
        $fatal(1, "done wait expired");
      end
      req = req & ~(NREQ'(1) << g);
    end
    dly_q.delete();
  endtask

  initial begin
    logic [7:0] c0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // T1: single request, full-speed frame, correct reply
    dir_q.push_back(K_OK);
    run_round(3'b001, {8'h00, 8'h00, 8'h3A}, 1'b0);

    // T2: simultaneous requests, twice, so the pointer advance shows up
    dir_q = {K_OK, K_OK};
    run_round(3'b011, 24'($urandom), 1'b0);
    dir_q = {K_OK, K_OK};
    run_round(3'b011, 24'($urandom), 1'b0);
    dir_q = {K_OK, K_OK, K_OK};
    run_round(3'b111, 24'($urandom), 1'b0);

    // T3: no reply at all -> three frames then timeout
    dir_q = {K_NONE, K_NONE, K_NONE};
    run_round(3'b100, 24'($urandom), 1'b0);

    // T4: error then correct; non-one-hot then status; reply exactly at expiry
    dir_q = {K_ERR, K_OK};
    run_round(3'b010, 24'($urandom), 1'b0);
    dir_q = {K_BAD, K_ST};
    run_round(3'b001, 24'($urandom), 1'b0);
    dir_q = {K_NONE, K_OK};
    dly_q = {TCYC - 1};
    run_round(3'b100, 24'($urandom), 1'b0);

    // T5: stalling TX with stale replies during SEND
    rdy_mode = 1;
    dir_q = {K_OK};
    run_round(3'b001, 24'($urandom), 1'b1);
    dir_q = {K_NONE, K_ST};
    run_round(3'b010, 24'($urandom), 1'b1);
    rdy_mode = 0;

    // T6: reset while waiting for a reply
    @(posedge clk);
    #1;
    c0 = 8'($urandom);
    push_frame(c0, 1'b0);
    cmd = {16'h0000, c0};
    req = 3'b001;
    wait_frame(1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req   = '0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    model_rr = 0;
    dir_q = {K_OK, K_OK};
    run_round(3'b110, 24'($urandom), 1'b0);

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      rdy_mode = int'($urandom % 2);
      run_round(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 24'($urandom), 1'($urandom % 2));
    end
    rdy_mode = 0;

    end_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
